// File: rtl/canny_pkg.sv
// Shared definitions for the Canny edge pipeline.
//   state_e : non-maximum-suppression sequencer states
//   dir_e   : quantised gradient direction produced by the Sobel stage
//   DEF_WIDTH / DEF_HEIGHT : default frame geometry
//   PIX_W / MAG_W : packed {dir, mag} word width and magnitude width
package canny_pkg;

  localparam int DEF_WIDTH  = 1280;
  localparam int DEF_HEIGHT = 720;
  localparam int PIX_W      = 10;
  localparam int MAG_W      = 8;

  typedef enum logic {
    PROLOGUE = 1'b0,
    RUN      = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    DIR_0   = 2'd0,  // W / E
    DIR_45  = 2'd1,  // NE / SW
    DIR_90  = 2'd2,  // N / S
    DIR_135 = 2'd3   // NW / SE
  } dir_e;

  // Centre survives when it is not smaller than either neighbour along the gradient.
  function automatic logic nms_keep(input logic [MAG_W-1:0] c,
                                    input logic [MAG_W-1:0] a,
                                    input logic [MAG_W-1:0] b);
    return (c >= a) && (c >= b);
  endfunction

endpackage

// File: rtl/nms_window.sv
// 3x3 raster window built from a (2*WIDTH+3)-entry shift register.
// New words enter at the tail (highest index); index 0 is the oldest (NW).
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-low reset (clears contents)
//   shift_en         : advance the register by one word
//   shift_din        : word entering at the tail
//   tap_nw .. tap_se : the nine window taps
module nms_window
  import canny_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DATA_W = PIX_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] shift_din,
  output logic [DATA_W-1:0] tap_nw,
  output logic [DATA_W-1:0] tap_n,
  output logic [DATA_W-1:0] tap_ne,
  output logic [DATA_W-1:0] tap_w,
  output logic [DATA_W-1:0] tap_c,
  output logic [DATA_W-1:0] tap_e,
  output logic [DATA_W-1:0] tap_sw,
  output logic [DATA_W-1:0] tap_s,
  output logic [DATA_W-1:0] tap_se
);

  localparam int DEPTH = 2 * WIDTH + 3;

  logic [DATA_W-1:0] sr_q [DEPTH];
  logic [DATA_W-1:0] sr_d [DEPTH];

  always_comb begin
    sr_d = sr_q;
    if (shift_en) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        sr_d[i] = sr_q[i+1];
      end
      sr_d[DEPTH-1] = shift_din;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  assign tap_nw = sr_q[0];
  assign tap_n  = sr_q[1];
  assign tap_ne = sr_q[2];
  assign tap_w  = sr_q[WIDTH];
  assign tap_c  = sr_q[WIDTH+1];
  assign tap_e  = sr_q[WIDTH+2];
  assign tap_sw = sr_q[2*WIDTH];
  assign tap_s  = sr_q[2*WIDTH+1];
  assign tap_se = sr_q[2*WIDTH+2];

endmodule

// File: rtl/non_maximum_suppression.sv
// Canny non-maximum suppression stage, FIFO in / FIFO out, one pixel per cycle.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-low reset
//   in_rd_en     : pop request to the input FIFO
//   in_empty     : input FIFO empty
//   in_dout      : {dir[9:8], mag[7:0]} from the Sobel stage
//   out_wr_en    : push request to the output FIFO
//   out_full     : output FIFO full
//   out_din      : suppressed magnitude (0 whenever out_wr_en is low)
module non_maximum_suppression
  import canny_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic             clock,
  input  logic             reset,
  output logic             in_rd_en,
  input  logic             in_empty,
  input  logic [PIX_W-1:0] in_dout,
  output logic             out_wr_en,
  input  logic             out_full,
  output logic [MAG_W-1:0] out_din
);

  localparam int CNT_W = $clog2(WIDTH * HEIGHT + 1);
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(WIDTH * HEIGHT);
  // in_cnt value at which the pop completing the prologue happens
  localparam logic [CNT_W-1:0] PRO_LAST  = CNT_W'(WIDTH + 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic             padding;
  logic             pop;
  logic             step;
  logic             shift_en;
  logic [PIX_W-1:0] shift_din;

  logic [PIX_W-1:0] tap_nw, tap_n, tap_ne, tap_w, tap_c, tap_e, tap_sw, tap_s, tap_se;
  logic [MAG_W-1:0] nbr_a, nbr_b;
  logic [MAG_W-1:0] nms_mag;
  logic             border;
  dir_e             dir;
  logic [15:0]      unused_dir_bits;

  // Once the whole frame has been read, the window is flushed with zero words.
  assign padding   = (in_cnt_q == PIX_TOTAL);
  assign shift_din = padding ? '0 : in_dout;

  nms_window #(
    .WIDTH  (WIDTH),
    .DATA_W (PIX_W)
  ) u_window (
    .clock     (clock),
    .reset     (reset),
    .shift_en  (shift_en),
    .shift_din (shift_din),
    .tap_nw    (tap_nw),
    .tap_n     (tap_n),
    .tap_ne    (tap_ne),
    .tap_w     (tap_w),
    .tap_c     (tap_c),
    .tap_e     (tap_e),
    .tap_sw    (tap_sw),
    .tap_s     (tap_s),
    .tap_se    (tap_se)
  );

  assign unused_dir_bits = {tap_nw[9:8], tap_n[9:8], tap_ne[9:8], tap_w[9:8],
                            tap_e[9:8], tap_sw[9:8], tap_s[9:8], tap_se[9:8]};

  // Sequencer: prologue fills the window up to the SE tap of pixel (0,0),
  // then every step emits one pixel and shifts one word in.
  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    col_d    = col_q;
    row_d    = row_q;
    pop      = 1'b0;
    step     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      PROLOGUE: begin
        if (!in_empty) begin
          pop      = 1'b1;
          shift_en = 1'b1;
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == PRO_LAST) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!out_full && (!in_empty || padding)) begin
          step     = 1'b1;
          shift_en = 1'b1;
          if (!padding) begin
            pop      = 1'b1;
            in_cnt_d = in_cnt_q + 1'b1;
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d    = '0;
              in_cnt_d = '0;
              state_d  = PROLOGUE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = PROLOGUE;
    endcase
  end

  // Suppression datapath on the current window.
  assign dir    = dir_e'(tap_c[9:8]);
  assign border = (row_q == '0) || (row_q == ROW_LAST) || (col_q == '0) || (col_q == COL_LAST);

  always_comb begin
    nbr_a = tap_w[7:0];
    nbr_b = tap_e[7:0];
    case (dir)
      DIR_0:   begin nbr_a = tap_w[7:0];  nbr_b = tap_e[7:0];  end
      DIR_45:  begin nbr_a = tap_ne[7:0]; nbr_b = tap_sw[7:0]; end
      DIR_90:  begin nbr_a = tap_n[7:0];  nbr_b = tap_s[7:0];  end
      DIR_135: begin nbr_a = tap_nw[7:0]; nbr_b = tap_se[7:0]; end
      default: begin nbr_a = tap_w[7:0];  nbr_b = tap_e[7:0];  end
    endcase
  end

  assign nms_mag = (border || !nms_keep(tap_c[7:0], nbr_a, nbr_b)) ? '0 : tap_c[7:0];

  // Handshakes are masked while reset is asserted so nothing moves in the reset cycle.
  always_comb begin
    in_rd_en  = reset & pop;
    out_wr_en = reset & step;
    out_din   = (reset && step) ? nms_mag : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= PROLOGUE;
      in_cnt_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

endmodule

// File: tb/tb_non_maximum_suppression.sv
module tb_non_maximum_suppression;

  localparam int W = 5;
  localparam int H = 4;
  localparam int N = W * H;

  typedef logic [9:0] frame_t [N];

  typedef struct {
    int dir;
    int cmag;
    int amag;
    int bmag;
    int expect_out;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_rd_en;
  logic       in_empty;
  logic [9:0] in_dout;
  logic       out_wr_en;
  logic       out_full;
  logic [7:0] out_din;

  always #5 clock = ~clock;

  non_maximum_suppression #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_rd_en  (in_rd_en),
    .in_empty  (in_empty),
    .in_dout   (in_dout),
    .out_wr_en (out_wr_en),
    .out_full  (out_full),
    .out_din   (out_din)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] src_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got [N];
  int out_idx    = 0;
  int frame_pops = 0;
  int writes     = 0;
  int pops       = 0;
  bit stall      = 1'b0;
  bit force_full = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: 2-D view of the frame, neighbours picked by gradient direction.
  function automatic logic [7:0] ref_pixel(input frame_t f, input int r, input int c);
    int dr, dc, cm, a, b;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'h00;
    case (int'(f[r*W+c][9:8]))
      0:       begin dr = 0;  dc = 1; end  // E, and W by symmetry
      1:       begin dr = -1; dc = 1; end  // NE, and SW
      2:       begin dr = 1;  dc = 0; end  // S, and N
      default: begin dr = 1;  dc = 1; end  // SE, and NW
    endcase
    cm = int'(f[r*W+c][7:0]);
    a  = int'(f[(r+dr)*W+(c+dc)][7:0]);
    b  = int'(f[(r-dr)*W+(c-dc)][7:0]);
    return (cm >= a && cm >= b) ? 8'(cm) : 8'h00;
  endfunction

  task automatic load_frame(input frame_t f);
    for (int i = 0; i < N; i++) begin
      src_q.push_back(f[i]);
      exp_q.push_back(ref_pixel(f, i / W, i % W));
    end
  endtask

  task automatic drive();
    in_empty = (src_q.size() == 0) || (stall && $urandom_range(0, 99) < 30);
    in_dout  = (src_q.size() != 0) ? src_q[0] : 10'h3FF;
    out_full = force_full || (stall && $urandom_range(0, 99) < 30);
  endtask

  task automatic sample();
    if (out_wr_en) begin
      if (out_idx == 0) check("first_write_latency", int'(frame_pops >= W + 2), 1);
      check("no_overflow", int'(out_full), 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_write: got write of %0d, required no write", out_din);
      end else begin
        check($sformatf("pixel_%0d", out_idx), int'(out_din), int'(exp_q.pop_front()));
      end
      got[out_idx] = out_din;
      writes++;
      if (out_idx == N - 1) begin
        out_idx    = 0;
        frame_pops = 0;
      end else begin
        out_idx++;
      end
    end else begin
      check("idle_out_zero", int'(out_din), 0);
    end
    if (in_rd_en) begin
      check("no_underflow", int'(in_empty), 0);
      if (src_q.size() != 0) void'(src_q.pop_front());
      frame_pops++;
      pops++;
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    sample();
    @(posedge clock);
    #1;
    drive();
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int k = 0;
    while (writes < target && k < budget) begin
      cycle();
      k++;
    end
    check(name, writes, target);
  endtask

  function automatic frame_t random_frame();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = 10'($urandom);
    return f;
  endfunction

  vec_t vecs [8];
  frame_t fr;
  int pops_before;
  int exp_all;

  initial begin
    vecs[0] = '{dir: 0, cmag: 50,  amag: 40,  bmag: 60,  expect_out: 0};
    vecs[1] = '{dir: 0, cmag: 50,  amag: 40,  bmag: 50,  expect_out: 50};
    vecs[2] = '{dir: 2, cmag: 80,  amag: 90,  bmag: 10,  expect_out: 0};
    vecs[3] = '{dir: 1, cmag: 80,  amag: 79,  bmag: 79,  expect_out: 80};
    vecs[4] = '{dir: 3, cmag: 100, amag: 101, bmag: 0,   expect_out: 0};
    vecs[5] = '{dir: 3, cmag: 100, amag: 100, bmag: 100, expect_out: 100};
    vecs[6] = '{dir: 1, cmag: 7,   amag: 8,   bmag: 0,   expect_out: 0};
    vecs[7] = '{dir: 2, cmag: 200, amag: 199, bmag: 200, expect_out: 200};

    // Reset with a non-empty input: nothing may be popped or written.
    reset    = 1'b0;
    in_empty = 1'b0;
    out_full = 1'b0;
    in_dout  = 10'h1FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("reset_rd_en", int'(in_rd_en), 0);
      check("reset_wr_en", int'(out_wr_en), 0);
      check("reset_out_din", int'(out_din), 0);
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    drive();
    for (int i = 0; i < 4; i++) cycle();

    // Directed centre-pixel cases at (1,1); off-axis neighbours are 255.
    for (int v = 0; v < 8; v++) begin
      int ar, ac, br, bc;
      case (vecs[v].dir)
        0:       begin ar = 1; ac = 0; br = 1; bc = 2; end
        1:       begin ar = 0; ac = 2; br = 2; bc = 0; end
        2:       begin ar = 0; ac = 1; br = 2; bc = 1; end
        default: begin ar = 0; ac = 0; br = 2; bc = 2; end
      endcase
      for (int i = 0; i < N; i++) fr[i] = {2'd0, 8'd255};
      fr[1*W+1]   = {2'(vecs[v].dir), 8'(vecs[v].cmag)};
      fr[ar*W+ac] = {2'd0, 8'(vecs[v].amag)};
      fr[br*W+bc] = {2'd0, 8'(vecs[v].bmag)};
      load_frame(fr);
      drive();
      run_until(writes + N, 200, $sformatf("vec%0d_frame_done", v));
      check($sformatf("vec%0d_centre", v), int'(got[W+1]), vecs[v].expect_out);
    end

    // Flat 255 frame: border zero, interior keeps.
    for (int i = 0; i < N; i++) fr[i] = {2'($urandom), 8'd255};
    load_frame(fr);
    drive();
    run_until(writes + N, 200, "flat255_done");
    for (int i = 0; i < N; i++) begin
      exp_all = (i / W == 0 || i / W == H - 1 || i % W == 0 || i % W == W - 1) ? 0 : 255;
      check($sformatf("flat255_%0d", i), int'(got[i]), exp_all);
    end

    // Output FIFO held full mid-frame: no pop, no write, word kept.
    load_frame(random_frame());
    drive();
    run_until(writes + 3, 100, "hold_prefix");
    force_full = 1'b1;
    drive();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("full_no_pop", int'(in_rd_en), 0);
      check("full_no_write", int'(out_wr_en), 0);
      @(posedge clock);
      #1;
      drive();
    end
    force_full = 1'b0;
    drive();
    run_until(writes + N - 3, 200, "hold_rest");

    // Three back-to-back random frames with random stalls on both FIFOs.
    stall       = 1'b1;
    pops_before = pops;
    for (int f = 0; f < 3; f++) load_frame(random_frame());
    drive();
    run_until(writes + 3 * N, 3000, "stall_3frames_done");
    for (int i = 0; i < 30; i++) cycle();
    check("stall_3frames_pops", pops - pops_before, 3 * N);
    stall = 1'b0;
    drive();

    // Reset after 9 outputs, then a clean frame.
    load_frame(random_frame());
    drive();
    run_until(writes + 9, 100, "midreset_prefix");
    reset = 1'b0;
    @(negedge clock);
    check("midreset_rd_en", int'(in_rd_en), 0);
    check("midreset_wr_en", int'(out_wr_en), 0);
    check("midreset_out_din", int'(out_din), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    src_q.delete();
    exp_q.delete();
    out_idx    = 0;
    frame_pops = 0;
    load_frame(random_frame());
    drive();
    run_until(writes + N, 200, "after_reset_frame_done");
    for (int i = 0; i < 10; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/non_maximum_suppression.md
NON_MAXIMUM_SUPPRESSION -- requirements
Module: non_maximum_suppression

Interface
REQ-001 Parameters, one per line:
  - WIDTH, 1280, pixels per row.
  - HEIGHT, 720, rows per frame.
REQ-002 Ports, one per line (clock and reset first):
  - clock  in  1  single clock, rising edge.
  - reset  in  1  synchronous, active-low (0 = reset).
  - in_rd_en  out  1  pop from input FIFO.
  - in_empty  in  1  input FIFO empty.
  - in_dout  in  10  {dir[9:8], mag[7:0]} from the Sobel stage.
  - out_wr_en  out  1  push to output FIFO (feeds hysteresis).
  - out_full  in  1  output FIFO full.
  - out_din  out  8  suppressed magnitude.
REQ-003 Direction code: 0 = 0 deg (W/E); 1 = 45 deg (NE/SW); 2 = 90 deg (N/S); 3 = 135 deg (NW/SE).

Function
REQ-004 Window: 10-bit shift register, 2*WIDTH+3 entries, raster order, new word enters at the tail. Index map:
  - NW=0, N=1, NE=2
  - W=WIDTH, C=WIDTH+1, E=WIDTH+2
  - SW=2*WIDTH, S=2*WIDTH+1, SE=2*WIDTH+2
REQ-005 Input counter in_cnt counts popped words, 0..WIDTH*HEIGHT.
  - Shift-in source = in_dout when in_cnt < WIDTH*HEIGHT.
  - Shift-in source = 10'h000 padding once in_cnt = WIDTH*HEIGHT; padding never asserts in_rd_en.
REQ-006 States: PROLOGUE, RUN.
REQ-007 PROLOGUE: each cycle with in_empty=0 pops and shifts one word. After the (WIDTH+2)-th pop, the next cycle is RUN.
REQ-008 RUN step condition: out_full=0 AND (in_empty=0 OR in_cnt=WIDTH*HEIGHT).
REQ-009 On each RUN step, in the same cycle:
  - compute out_din for pixel (row,col) from the current window;
  - assert out_wr_en;
  - shift the register;
  - pop the input if not padding;
  - advance col/row.
  No step occurs otherwise, and all state holds.
REQ-010 Border pixels (row 0, row HEIGHT-1, col 0, col WIDTH-1) output 8'h00.
REQ-011 Interior pixels: out_din = C.mag when C.mag >= both neighbour mags along dir[C] (unsigned 8-bit compare); otherwise 8'h00.
REQ-012 out_din = 8'h00 whenever out_wr_en=0.
REQ-013 Counters: col wraps WIDTH-1 -> 0 with row+1. After the step for (HEIGHT-1, WIDTH-1):
  - row, col and in_cnt clear;
  - state -> PROLOGUE;
  - shift-register contents retained (overwritten by the next frame).
REQ-014 Latency: the first out_wr_en occurs no earlier than the cycle after the (WIDTH+2)-th pop.
  - Throughput is 1 pixel/cycle when the input is non-empty and the output is not full.
REQ-015 Exactly WIDTH*HEIGHT outputs per frame; each output is written once. No drop or duplicate under any pattern of in_empty/out_full.
REQ-016 out_full=1 with in_empty=0 produces no pop; the FIFO word is preserved.

Reset
REQ-017 reset=0 sampled at a rising edge sets state=PROLOGUE, row=col=in_cnt=prologue count=0, and the shift register to all zeros.
REQ-018 During and after reset: in_rd_en=0, out_wr_en=0, out_din=8'h00.
REQ-019 Reset mid-frame discards the partial frame; the next accepted word is treated as pixel (0,0).

Structure
REQ-020 Shared package canny_pkg holds:
  - state typedef (PROLOGUE, RUN);
  - direction typedef (DIR_0, DIR_45, DIR_90, DIR_135);
  - default WIDTH/HEIGHT constants.
REQ-021 One sub-module, nms_window: the parameterised shift register with enable and shift-in data; it exposes the 9 window taps.

Verification (WIDTH=5, HEIGHT=4 unless noted)
REQ-022 Interior (1,1): C=50 dir=0, W=40, E=60 -> out 0. Repeat with E=50 -> out 50 (equality keeps).
REQ-023 Interior: C=80 dir=2, N=90, S=10 -> out 0. C=80 dir=1, NE=SW=79 -> out 80.
REQ-024 All pixels mag=255 -> 20 outputs: the 14 border pixels = 0 and the 6 interior pixels = 255.
REQ-025 Random in_empty/out_full toggling at 30% each over 3 back-to-back frames -> each frame is exactly 20 writes, output matches the golden model, no FIFO underflow or overflow.
REQ-026 reset=0 asserted after 9 outputs, then a fresh frame -> outputs match a clean single frame. in_rd_en and out_wr_en are 0 in the reset cycle.
